// File: rtl/wand_pkg.sv
// Shared types for the wired-AND arbitration transmitter.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Holds the FSM state enum, bus level constants and a width helper.
package wand_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_ARB,
        ST_DATA,
        ST_EOF,
        ST_WAIT
    } state_t;

    localparam logic DOMINANT  = 1'b0;
    localparam logic RECESSIVE = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/wand_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYC-1 while run is high, clears when idle.
// Latency: sample/tick are combinational on the last cycle of each bit period.
// Backpressure: none; the count free-runs whenever run=1.
module wand_bit_timer #(
    parameter int BIT_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick,
    output logic sample
);
    import wand_pkg::*;

    localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // The wrap cycle is also the readback cycle, so both strobes coincide.
    assign sample = run && (cnt == LAST);
    assign tick   = run && (cnt == LAST);

endmodule

// File: rtl/wand_arb_tx.sv
// Wired-AND bus transmitter: SOF, ID, DATA, EOF with bitwise arbitration; optional WAND_ARB_RETRY_EN.
// Latency: done pulses (1+ID_W+DATA_W+EOF_BITS)*BIT_CYC+1 cycles after the start acceptance cycle.
// Backpressure: start is only accepted in IDLE with the bus released; otherwise it is ignored, not latched.
module wand_arb_tx #(
    parameter int ID_W     = 8,
    parameter int DATA_W   = 8,
    parameter int BIT_CYC  = 4,
    parameter int EOF_BITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ID_W-1:0]   id,
    input  logic [DATA_W-1:0] data,
    input  logic              bus_in,
    output logic              bus_out,
    output logic              busy,
    output logic              done,
    output logic              arb_lost,
    output logic              bit_err
);
    import wand_pkg::*;

    localparam int IDX_W = $clog2(max3(ID_W, DATA_W, EOF_BITS) + 1);
    localparam logic [IDX_W-1:0] ID_LAST   = IDX_W'(ID_W - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] EOF_LAST  = IDX_W'(EOF_BITS - 1);

    state_t            state, state_n;
    logic [ID_W-1:0]   id_sh;
    logic [DATA_W-1:0] data_sh;
    logic [IDX_W-1:0]  bit_idx;
    logic              busy_q, done_q, lost_q, err_q;
    logic              done_n, lost_n, err_n, accept;
    logic              drv_bit;
    logic              tick, sample;

`ifdef WAND_ARB_RETRY_EN
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  idle_cnt;
    logic              period_ok;
    logic              clean_bit;

    // A bit period counts as idle only if the bus stayed released for all of it.
    assign clean_bit = period_ok && (bus_in == RECESSIVE);
`endif

    wand_bit_timer #(
        .BIT_CYC (BIT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state != ST_IDLE),
        .tick   (tick),
        .sample (sample)
    );

    always_comb begin
        drv_bit = RECESSIVE;
        case (state)
            ST_SOF:  drv_bit = DOMINANT;
            ST_ARB:  drv_bit = id_sh[ID_W-1];
            ST_DATA: drv_bit = data_sh[DATA_W-1];
            default: drv_bit = RECESSIVE;
        endcase
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        lost_n  = 1'b0;
        err_n   = 1'b0;
        accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && (bus_in == RECESSIVE)) begin
                    accept  = 1'b1;
                    state_n = ST_SOF;
                end
            end
            ST_SOF: begin
                if (sample) begin
                    if (bus_in != DOMINANT) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_ARB;
                    end
                end
            end
            ST_ARB: begin
                if (sample) begin
                    if (bus_in != drv_bit) begin
                        // Recessive overridden means another agent won; the reverse cannot happen on a sound bus.
                        if (drv_bit == RECESSIVE) begin
                            lost_n = 1'b1;
`ifdef WAND_ARB_RETRY_EN
                            state_n = ST_WAIT;
`else
                            state_n = ST_IDLE;
`endif
                        end else begin
                            err_n   = 1'b1;
                            state_n = ST_IDLE;
                        end
                    end else if (bit_idx == ID_LAST) begin
                        state_n = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    if (bus_in != drv_bit) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else if (bit_idx == DATA_LAST) begin
                        state_n = ST_EOF;
                    end
                end
            end
            ST_EOF: begin
                if (tick && (bit_idx == EOF_LAST)) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
`ifdef WAND_ARB_RETRY_EN
            ST_WAIT: begin
                if (tick && clean_bit && (idle_cnt == EOF_LAST)) begin
                    state_n = ST_SOF;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            id_sh   <= '0;
            data_sh <= '0;
            bit_idx <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state  <= state_n;
            busy_q <= (state_n != ST_IDLE);
            done_q <= done_n;
            lost_q <= lost_n;
            err_q  <= err_n;

            if (state_n != state) begin
                bit_idx <= '0;
            end else if (tick) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (accept) begin
                id_sh   <= id;
                data_sh <= data;
`ifdef WAND_ARB_RETRY_EN
            end else if ((state == ST_WAIT) && (state_n == ST_SOF)) begin
                id_sh   <= id_q;
                data_sh <= data_q;
`endif
            end else if (tick && (state == ST_ARB)) begin
                id_sh <= id_sh << 1;
            end else if (tick && (state == ST_DATA)) begin
                data_sh <= data_sh << 1;
            end
        end
    end

`ifdef WAND_ARB_RETRY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q      <= '0;
            data_q    <= '0;
            idle_cnt  <= '0;
            period_ok <= 1'b1;
        end else begin
            if (accept) begin
                id_q   <= id;
                data_q <= data;
            end
            if (state != ST_WAIT) begin
                idle_cnt  <= '0;
                period_ok <= 1'b1;
            end else if (tick) begin
                idle_cnt  <= clean_bit ? idle_cnt + 1'b1 : '0;
                period_ok <= 1'b1;
            end else begin
                period_ok <= clean_bit;
            end
        end
    end
`endif

    assign bus_out  = drv_bit;
    assign busy     = busy_q;
    assign done     = done_q;
    assign arb_lost = lost_q;
    assign bit_err  = err_q;

endmodule

// File: tb/tb_wand_arb_tx.sv
// Bench for wand_arb_tx: two agents on a wired-AND net plus a bench pull-down.
// Timing below is counted in clock edges after the acceptance edge (k=0).
module tb_wand_arb_tx;

    localparam int BC         = 4;
    localparam int FRAME_BITS = 20;
    localparam int DONE_K     = FRAME_BITS * BC;

    typedef struct {
        logic [7:0]  id;
        logic [7:0]  data;
        logic        hold;
        logic [19:0] frame;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, start_b;
    logic [7:0] id_a, id_b, data_a, data_b;
    logic       force_lo;
    logic       bus;
    logic       bus_out_a, busy_a, done_a, arb_lost_a, bit_err_a;
    logic       bus_out_b, busy_b, done_b, arb_lost_b, bit_err_b;

    int   total = 0;
    int   bad   = 0;
    logic exp_q[$];
    vec_t vecs[3];

    always #5 clk = ~clk;

    assign bus = bus_out_a & bus_out_b & ~force_lo;

    wand_arb_tx u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .id(id_a), .data(data_a),
        .bus_in(bus), .bus_out(bus_out_a), .busy(busy_a), .done(done_a),
        .arb_lost(arb_lost_a), .bit_err(bit_err_a)
    );

    wand_arb_tx u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .id(id_b), .data(data_b),
        .bus_in(bus), .bus_out(bus_out_b), .busy(busy_b), .done(done_b),
        .arb_lost(arb_lost_b), .bit_err(bit_err_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        force_lo = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_frame(input vec_t v);
        int   spur;
        logic e;
        id_a    = v.id;
        data_a  = v.data;
        start_a = 1'b1;
        step();
        if (!v.hold) start_a = 1'b0;
        for (int i = FRAME_BITS - 1; i >= 0; i--) exp_q.push_back(v.frame[i]);
        chk_b("accept_busy", busy_a, 1'b1);
        spur = 0;
        for (int k = 0; k <= DONE_K; k++) begin
            if (k < DONE_K) begin
                if ((k % BC) == 1) begin
                    e = exp_q.pop_front();
                    chk_b($sformatf("frame_%02h_bit%0d", v.id, k / BC), bus_out_a, e);
                end
                if (done_a || arb_lost_a || bit_err_a || !busy_a) spur++;
                step();
            end
        end
        chk_b("frame_done", done_a, 1'b1);
        chk_b("frame_busy_end", busy_a, 1'b0);
        chk_i("frame_spurious", spur, 0);
        chk_i("frame_queue_empty", exp_q.size(), 0);
        if (v.hold) begin
            step();
            chk_b("retrigger_busy", busy_a, 1'b1);
            chk_b("retrigger_done_low", done_a, 1'b0);
            start_a = 1'b0;
            do_reset();
        end else begin
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int spur;
        int spur_b;

        vecs[0] = '{id: 8'h5A, data: 8'hC3, hold: 1'b0, frame: 20'b0_01011010_11000011_111};
        vecs[1] = '{id: 8'h00, data: 8'hFF, hold: 1'b0, frame: 20'b0_00000000_11111111_111};
        vecs[2] = '{id: 8'hFF, data: 8'h00, hold: 1'b1, frame: 20'b0_11111111_00000000_111};

        id_a = 8'h00; id_b = 8'h00; data_a = 8'h00; data_b = 8'h00;
        do_reset();
        chk_b("rst_bus_out", bus_out_a, 1'b1);
        chk_b("rst_busy", busy_a, 1'b0);
        chk_b("rst_done", done_a, 1'b0);
        chk_b("rst_arb_lost", arb_lost_a, 1'b0);
        chk_b("rst_bit_err", bit_err_a, 1'b0);

        for (int i = 0; i < 3; i++) run_frame(vecs[i]);

        // Two agents, 0x12 beats 0x13 at the last ID bit.
        id_a = 8'h12; data_a = 8'h96;
        id_b = 8'h13; data_b = 8'hA5;
        start_a = 1'b1;
        start_b = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        spur   = 0;
        spur_b = 0;
        for (int k = 0; k <= 2 * DONE_K; k++) begin
            if (k == 35) chk_b("loser_lost_early", arb_lost_b, 1'b0);
            if (k == 36) begin
                chk_b("loser_arb_lost", arb_lost_b, 1'b1);
                chk_b("loser_released", bus_out_b, 1'b1);
`ifdef WAND_ARB_RETRY_EN
                chk_b("loser_busy_wait", busy_b, 1'b1);
`else
                chk_b("loser_busy_drop", busy_b, 1'b0);
`endif
            end
            if (k == 37) chk_b("loser_pulse_one", arb_lost_b, 1'b0);
            if (k == DONE_K) chk_b("winner_done", done_a, 1'b1);
            else if (done_a || arb_lost_a || bit_err_a) spur++;
            if (k != 36 && (arb_lost_b || bit_err_b)) spur_b++;
`ifdef WAND_ARB_RETRY_EN
            if (k < 2 * DONE_K && (!busy_b || done_b)) spur_b++;
            if (k == 2 * DONE_K) begin
                chk_b("retry_done", done_b, 1'b1);
                chk_b("retry_busy_end", busy_b, 1'b0);
            end
`else
            if (k > 36 && (busy_b || done_b || !bus_out_b)) spur_b++;
`endif
            if (k < 2 * DONE_K) step();
        end
        chk_i("winner_spurious", spur, 0);
        chk_i("loser_spurious", spur_b, 0);
        do_reset();

        // Pull the bus low during DATA value bit 2 (transmitted 6th, driven 1).
        id_a = 8'h5A; data_a = 8'h24;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 0; k <= 61; k++) begin
            if (k == 59) chk_b("err_not_yet", bit_err_a, 1'b0);
            if (k == 60) begin
                force_lo = 1'b0;
                chk_b("err_pulse", bit_err_a, 1'b1);
                chk_b("err_released", bus_out_a, 1'b1);
                chk_b("err_busy", busy_a, 1'b0);
                chk_b("err_no_lost", arb_lost_a, 1'b0);
            end
            if (k == 61) chk_b("err_one_cycle", bit_err_a, 1'b0);
            if (k == 56) force_lo = 1'b1;
            if (k < 61) step();
        end
        do_reset();

        // start held while the bus is low, then accepted once it is released.
        id_a = 8'h5A; data_a = 8'hC3;
        force_lo = 1'b1;
        start_a  = 1'b1;
        spur = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy_a) spur++;
        end
        chk_i("holdoff_no_accept", spur, 0);
        force_lo = 1'b0;
        step();
        chk_b("holdoff_accept", busy_a, 1'b1);
        start_a = 1'b0;
        for (int k = 0; k < 17; k++) step();
        chk_b("arb_bit3_drive", bus_out_a, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_b("midrst_bus_out", bus_out_a, 1'b1);
        chk_b("midrst_busy", busy_a, 1'b0);
        chk_b("midrst_done", done_a, 1'b0);
        chk_b("midrst_arb_lost", arb_lost_a, 1'b0);
        chk_b("midrst_bit_err", bit_err_a, 1'b0);
        spur = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (busy_a || done_a || arb_lost_a || bit_err_a || !bus_out_a) spur++;
        end
        chk_i("midrst_quiet", spur, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wand_arb_tx.md
Name: wand_arb_tx

Overview:
- Serial transmitter that drives one leg of a triand (wired-AND) bus.
- Dominant level is 0. Recessive level is 1 (released).
- Sends a frame with bitwise arbitration: SOF, then ID (MSB first), then DATA (MSB first), then EOF.
- Reads the resolved bus back to detect lost arbitration and bit errors. Instances sit directly upstream of the triand net, one per bus agent.

Parameters:
- ID_W, 8, identifier width in bits. A lower ID wins arbitration.
- DATA_W, 8, payload width in bits.
- BIT_CYC, 4, clock cycles per bit period. Minimum 2.
- EOF_BITS, 3, recessive bits driven at the end of a frame.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request to transmit. Sampled only in IDLE.
- id  input  ID_W  frame identifier. Captured when start is accepted.
- data  input  DATA_W  payload. Captured when start is accepted.
- bus_in  input  1  resolved value of the triand net.
- bus_out  output  1  this agent's drive onto the triand net. 1 means released.
- busy  output  1  high from start acceptance until the frame ends or aborts.
- done  output  1  one-cycle pulse on successful frame completion.
- arb_lost  output  1  one-cycle pulse when arbitration is lost.
- bit_err  output  1  one-cycle pulse on readback mismatch in SOF or DATA.

Behaviour:
- Reset is synchronous. On clk with rst_n=0:
  - state=IDLE, bus_out=1, busy=0, done=0, arb_lost=0, bit_err=0.
  - Bit counters and shift registers clear to 0.
  - Reset mid-frame aborts the frame with no pulse.
- Start acceptance:
  - In IDLE with start=1 and bus_in=1, the block captures id and data and moves to SOF on the next cycle. busy goes high on that same edge.
  - If bus_in=0, start is ignored and held off until the bus is idle. No latching.
- Bit timing:
  - Each bit is driven on bus_out for exactly BIT_CYC cycles.
  - bus_in is sampled in the last cycle of each bit period (cycle index BIT_CYC-1).
  - The state or bit advances on the following edge.
- States:
  - IDLE -> SOF -> ARB -> DATA -> EOF -> IDLE.
  - SOF drives one dominant bit. If the sample reads 1: bit_err pulse, go to IDLE.
  - ARB drives ID_W bits.
    - If a recessive bit is driven and 0 is sampled: arb_lost pulse, bus_out=1 immediately on the next edge, busy=0, go to IDLE.
    - Driving dominant and sampling recessive is impossible on a wired-AND bus, so this case is treated as bit_err with an abort.
  - DATA drives DATA_W bits. Any mismatch: bit_err pulse, abort to IDLE, bus released.
  - EOF drives EOF_BITS recessive bits with no checking. At the end: done pulse, busy=0, IDLE.
- Frame latency from start acceptance to done: (1 + ID_W + DATA_W + EOF_BITS) × BIT_CYC cycles + 1.
- Pulses are mutually exclusive and last exactly one cycle.
- start while busy is ignored.
- Back-to-back: start held high at done retriggers from IDLE on the next cycle, subject to bus_in=1.
- Counters:
  - Bit-cycle counter width is $clog2(BIT_CYC).
  - Bit index width is $clog2(max(ID_W, DATA_W, EOF_BITS)+1).
  - No wrap: the counter resets on every bit advance.

Optional Feature:
- Macro: WAND_ARB_RETRY_EN.
- Defined:
  - After arb_lost, the block keeps busy=1 and enters WAIT.
  - It waits for bus_in to be 1 for EOF_BITS consecutive whole bit periods, then re-enters SOF with the captured id/data.
  - Each loss still pulses arb_lost.
  - bit_err still aborts with no retry.
- Undefined: arb_lost aborts to IDLE as described above. The WAIT state does not exist.

Decomposition:
- Package wand_pkg holds:
  - state enum (IDLE, SOF, ARB, DATA, EOF, WAIT);
  - constants DOMINANT=1'b0 and RECESSIVE=1'b1.
- Sub-module wand_bit_timer(clk, rst_n, run, tick, sample):
  - counts 0..BIT_CYC-1 while run=1;
  - sample is high at count BIT_CYC-1;
  - tick is high on the wrap.

Test Plan:
- Single agent, ID=8'h5A, DATA=8'hC3, BIT_CYC=4 -> bus shows 0, 01011010, 11000011, 111. done pulses 81 cycles after acceptance. No errors.
- Two instances on a triand net, IDs 8'h12 vs 8'h13, started on the same cycle:
  - the 8'h13 agent pulses arb_lost at the sample of ID bit 0 and releases the bus;
  - the 8'h12 agent completes with done.
- Single agent with a bench force of bus_in=0 during DATA bit 2, where a 1 is driven -> bit_err pulse, bus_out=1, busy=0 next cycle.
- start=1 while bus_in=0 for 10 cycles, then bus_in=1 -> no acceptance during the low period; busy rises on the first cycle bus_in=1.
- rst_n=0 asserted during ARB bit 3 -> next cycle all outputs at reset values. No pulses.
- With WAIT-RETRY enabled, repeat the two-agent test -> the losing agent retransmits after 3 idle bits and finishes with done. busy stays high throughout.
